program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 180 ++++++++++++++++++
 tb/tb_program_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//   Receives a framed program image over a byte-wide valid/ready link and
//   writes it into instruction memory. The CPU is released from reset once a
//   full frame with a matching checksum has been loaded.
//
//   Frame: 0xA5, N[15:8], N[7:0], N words (DATA_WIDTH/8 bytes each, MSB
//   first), then one checksum byte equal to the XOR of all word bytes.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous active-high reset
//   in_data       byte from host link
//   in_valid      in_data valid
//   in_ready      loader can accept a byte (transfer = in_valid && in_ready)
//   imem_addr     instruction memory write address
//   imem_wvalue   instruction word to write
//   imem_wenable  one-cycle write strobe
//   cpu_nreset    active-low CPU reset, high only in RUN
//   busy          high from sync byte until the checksum byte is consumed
//   error         sticky load failure (cleared by the next sync byte)
//   words_loaded  number of words written in the current load
// ---------------------------------------------------------------------------
module program_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] imem_wvalue,
   output logic                  imem_wenable,
   output logic                  cpu_nreset,
   output logic                  busy,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam int              BYTES     = DATA_WIDTH / 8;
   localparam int              BCW       = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BYTES - 1);
   // Largest legal word count; lengths above this would wrap the address.
   localparam logic [16:0]     MAX_WORDS = 17'(2 ** ADDR_WIDTH);
   localparam logic [7:0]      SYNC      = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
      CHECK,
      RUN
   } state_t;

   state_t                  state;
   logic [15:0]             len;
   logic [7:0]              csum;
   logic [DATA_WIDTH-1:0]   word_reg;
   logic [BCW-1:0]          byte_cnt;

   logic                    take;
   logic [15:0]             len_n;
   logic [DATA_WIDTH-1:0]   word_n;
   logic [ADDR_WIDTH:0]     wl_n;
   logic                    last_word;

   assign take      = in_valid && in_ready;
   assign len_n     = {len[15:8], in_data};
   // Shift in MSB-first; the shift form also covers DATA_WIDTH == 8.
   assign word_n    = (word_reg << 8) | DATA_WIDTH'(in_data);
   assign wl_n      = words_loaded + 1'b1;
   // words_loaded is bumped on the accepting edge of each word's last byte,
   // so the word being completed now is number wl_n.
   assign last_word = (17'(wl_n) == {1'b0, len});

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         len          <= '0;
         csum         <= '0;
         word_reg     <= '0;
         byte_cnt     <= '0;
         in_ready     <= 1'b1;
         imem_addr    <= '0;
         imem_wvalue  <= '0;
         imem_wenable <= 1'b0;
         cpu_nreset   <= 1'b0;
         busy         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
      end else begin
         // Strobe is a single cycle; address/data simply hold.
         imem_wenable <= 1'b0;

         case (state)
            IDLE: begin
               if (take && in_data == SYNC) begin
                  state        <= LEN_HI;
                  error        <= 1'b0;
                  words_loaded <= '0;
                  csum         <= '0;
                  byte_cnt     <= '0;
                  busy         <= 1'b1;
               end
            end

            LEN_HI: begin
               if (take) begin
                  len[15:8] <= in_data;
                  state     <= LEN_LO;
               end
            end

            LEN_LO: begin
               if (take) begin
                  len[7:0] <= in_data;
                  byte_cnt <= '0;
                  if ({1'b0, len_n} > MAX_WORDS) begin
                     error <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else if (len_n == 16'd0) begin
                     state <= CHECK;
                  end else begin
                     state <= DATA;
                  end
               end
            end

            DATA: begin
               // in_ready stays high here, so a byte can land in the same
               // cycle the previous word's write strobe is out.
               if (take) begin
                  csum     <= csum ^ in_data;
                  word_reg <= word_n;
                  if (byte_cnt == LAST_BYTE) begin
                     byte_cnt     <= '0;
                     imem_wenable <= 1'b1;
                     imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
                     imem_wvalue  <= word_n;
                     words_loaded <= wl_n;
                     if (last_word)
                        state <= CHECK;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end

            CHECK: begin
               if (take) begin
                  busy <= 1'b0;
                  if (in_data == csum) begin
                     state      <= RUN;
                     cpu_nreset <= 1'b1;
                     in_ready   <= 1'b0;
                  end else begin
                     error <= 1'b1;
                     state <= IDLE;
                  end
               end
            end

            RUN: begin
               // Terminal until reset; the host link is ignored.
               cpu_nreset <= 1'b1;
               in_ready   <= 1'b0;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//   Self-checking bench for program_loader. Expected memory writes are queued
//   as frames are driven and checked against the write strobe as it appears.
// ---------------------------------------------------------------------------
module tb_program_loader;

   localparam int AW = 8;
   localparam int DW = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_wvalue;
   logic          imem_wenable;
   logic          cpu_nreset;
   logic          busy;
   logic          error;
   logic [AW:0]   words_loaded;

   program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clock        (clock),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .imem_addr    (imem_addr),
      .imem_wvalue  (imem_wvalue),
      .imem_wenable (imem_wenable),
      .cpu_nreset   (cpu_nreset),
      .busy         (busy),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;

   typedef struct {
      int n;
      bit bad_csum;
      int maxgap;
      bit garbage;
      bit exp_err;
      bit exp_run;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Write monitor / scoreboard consumer.
   always @(negedge clock) begin
      if (!reset && imem_wenable === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                     imem_addr, imem_wvalue);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr",  32'(imem_addr),    32'(mon_e.addr));
            check("wr_data",  32'(imem_wvalue),  32'(mon_e.data));
            check("wr_count", 32'(words_loaded), 32'(mon_e.addr) + 1);
            check("wr_ready", 32'(in_ready),     32'd1);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clock);
         #1;
      end
      in_data  = b;
      in_valid = 1'b1;
      waited   = 0;
      while (1) begin
         @(negedge clock);
         if (in_ready === 1'b1) break;
         waited++;
         if (waited > 20) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: byte %0h not accepted, in_ready %0b", b, in_ready);
            break;
         end
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic rand_gap(input int maxgap, output int g);
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
   endtask

   task automatic send_frame(input int n, input bit bad_csum, input int maxgap, input bit garbage);
      logic [7:0]  cs;
      logic [7:0]  b;
      logic [DW-1:0] w;
      logic [15:0] n16;
      int g;
      cs  = 8'h00;
      n16 = 16'(n);
      if (garbage) begin
         rand_gap(maxgap, g); send_byte(8'h00, g);
         rand_gap(maxgap, g); send_byte(8'hFF, g);
         rand_gap(maxgap, g); send_byte(8'h5A, g);
      end
      rand_gap(maxgap, g); send_byte(8'hA5, g);
      rand_gap(maxgap, g); send_byte(n16[15:8], g);
      rand_gap(maxgap, g); send_byte(n16[7:0], g);
      for (int i = 0; i < n; i++) begin
         // First word carries sync-valued bytes to show they are plain data.
         w = (i == 0) ? 16'hA5A5 : DW'($urandom);
         for (int j = 0; j < DW / 8; j++) begin
            b  = w[DW-1-8*j -: 8];
            cs = cs ^ b;
            if (j == DW / 8 - 1) exp_q.push_back('{addr: AW'(i), data: w});
            rand_gap(maxgap, g);
            send_byte(b, g);
         end
      end
      rand_gap(maxgap, g);
      send_byte(bad_csum ? (cs ^ 8'h01) : cs, g);
   endtask

   task automatic check_end(input string name, input bit e_err, input bit e_run, input int e_wl);
      @(negedge clock);
      @(negedge clock);
      check({name, "_error"},  32'(error),        32'(e_err));
      check({name, "_run"},    32'(cpu_nreset),   32'(e_run));
      check({name, "_busy"},   32'(busy),         32'd0);
      check({name, "_words"},  32'(words_loaded), 32'(e_wl));
      check({name, "_ready"},  32'(in_ready),     32'(!e_run));
      check({name, "_qempty"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset    = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_ready"},  32'(in_ready),     32'd1);
      check({name, "_nrst"},   32'(cpu_nreset),   32'd0);
      check({name, "_wen"},    32'(imem_wenable), 32'd0);
      check({name, "_busy"},   32'(busy),         32'd0);
      check({name, "_error"},  32'(error),        32'd0);
      check({name, "_words"},  32'(words_loaded), 32'd0);
      check({name, "_addr"},   32'(imem_addr),    32'd0);
      check({name, "_wvalue"}, 32'(imem_wvalue),  32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //            n    bad gap garb err run
      vecs[0] = '{  2,   0,  0,  0,   0,  1 };
      vecs[1] = '{  2,   1,  0,  0,   1,  0 };
      vecs[2] = '{  5,   0,  3,  1,   0,  1 };
      vecs[3] = '{  1,   0,  0,  0,   0,  1 };
      vecs[4] = '{  0,   0,  0,  0,   0,  1 };
      vecs[5] = '{  0,   1,  2,  0,   1,  0 };
      vecs[6] = '{  3,   0,  2,  1,   0,  1 };

      // Reset state while reset is held.
      #12;
      check_reset_outputs("rst");
      @(posedge clock);
      #1;
      reset = 1'b0;

      for (int v = 0; v < 7; v++) begin
         do_reset();
         send_frame(vecs[v].n, vecs[v].bad_csum, vecs[v].maxgap, vecs[v].garbage);
         check_end($sformatf("vec%0d", v), vecs[v].exp_err, vecs[v].exp_run, vecs[v].n);
      end

      // Fixed frame; XOR of 12 34 56 78 is 08.
      do_reset();
      exp_q.push_back('{addr: 8'd0, data: 16'h1234});
      exp_q.push_back('{addr: 8'd1, data: 16'h5678});
      send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
      send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0);
      send_byte(8'h78, 0);
      check("fix_busy_before", 32'(busy),       32'd1);
      check("fix_nrst_before", 32'(cpu_nreset), 32'd0);
      send_byte(8'h08, 0);
      @(negedge clock);
      check("fix_nrst_next", 32'(cpu_nreset), 32'd1);
      check_end("fix", 1'b0, 1'b1, 2);

      // Same frame with a wrong checksum.
      do_reset();
      exp_q.push_back('{addr: 8'd0, data: 16'h1234});
      exp_q.push_back('{addr: 8'd1, data: 16'h5678});
      send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
      send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0);
      send_byte(8'h78, 0); send_byte(8'h2D, 0);
      check_end("badcs", 1'b1, 1'b0, 2);

      // Oversized length: 257 words rejected, then an empty frame loads.
      do_reset();
      send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h01, 0);
      @(negedge clock);
      check("ovf_error", 32'(error), 32'd1);
      check("ovf_busy",  32'(busy),  32'd0);
      send_byte(8'h12, 0); send_byte(8'h34, 0);
      send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      check_end("ovf_retry", 1'b0, 1'b1, 0);

      // Reset after the first word is written, then a fresh frame.
      do_reset();
      exp_q.push_back('{addr: 8'd0, data: 16'hBEEF});
      send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
      send_byte(8'hBE, 0); send_byte(8'hEF, 0);
      @(negedge clock);
      check("mid_words_pre", 32'(words_loaded), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      check_reset_outputs("mid");
      @(posedge clock);
      #1;
      reset = 1'b0;
      send_frame(2, 1'b0, 0, 1'b0);
      check_end("mid_fresh", 1'b0, 1'b1, 2);

      // Full address space, back to back.
      do_reset();
      send_frame(256, 1'b0, 0, 1'b0);
      check_end("full", 1'b0, 1'b1, 256);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
